// File: rtl/out_accum_buffer.sv
// Output accumulation buffer: read-modify-write accumulate of MAC results, requantized readout.
// Define ACC_SAT_EN to saturate overflowing sums instead of wrapping them.
module out_accum_buffer #(
    parameter int ADDR_W = 13,
    parameter int SHIFT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              data_validity,
    input  logic [23:0]       data,
    input  logic [ADDR_W-1:0] address,
    input  logic              clr_acc,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              overflow,
    output logic [ADDR_W:0]   wr_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [23:0]       mem [DEPTH];
    logic [23:0]       acc_rd_q;
    logic [23:0]       rd_mem_q;

    logic              s1_valid_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [23:0]       s1_data_q;
    logic              s1_clr_q;
    logic              s2_valid_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [23:0]       s2_sum_q;
    logic              rd_valid_q;
    logic              overflow_q, overflow_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;

    logic [23:0]       old_val;
    logic [23:0]       add_raw;
    logic [23:0]       add_res;
    logic              add_ovf;
    logic [23:0]       sum_d;
    logic              wr_en;
    logic [23:0]       rd_shift;
    logic [7:0]        rd_quant;

    // S1 holds the captured sample while its memory read returns; the sum is
    // written at the end of that cycle. S2 remembers the last write so a
    // back-to-back sample to the same address sees it instead of the stale read.
    assign wr_en   = s1_valid_q;
    assign old_val = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_sum_q : acc_rd_q;
    assign add_raw = old_val + s1_data_q;
    assign add_ovf = (old_val[23] == s1_data_q[23]) && (add_raw[23] != old_val[23]);

`ifdef ACC_SAT_EN
    assign add_res = add_ovf ? (old_val[23] ? 24'h800000 : 24'h7FFFFF) : add_raw;
`else
    assign add_res = add_raw;
`endif

    assign sum_d = s1_clr_q ? s1_data_q : add_res;

    always_comb begin
        overflow_d = overflow_q;
        if (start)
            overflow_d = 1'b0;
        if (wr_en && !s1_clr_q && add_ovf)
            overflow_d = 1'b1;
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (start)
            wr_count_d = wr_en ? CNT_ONE : '0;
        else if (wr_en && (wr_count_q != CNT_MAX))
            wr_count_d = wr_count_q + CNT_ONE;
    end

    // No reset on the array or its read registers so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (data_validity)
            acc_rd_q <= mem[address];
        if (rd_en)
            rd_mem_q <= mem[rd_addr];
        if (wr_en)
            mem[s1_addr_q] <= sum_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            s1_clr_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_sum_q   <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            s1_valid_q <= data_validity;
            if (data_validity) begin
                s1_addr_q <= address;
                s1_data_q <= data;
                s1_clr_q  <= clr_acc;
            end
            s2_valid_q <= wr_en;
            if (wr_en) begin
                s2_addr_q <= s1_addr_q;
                s2_sum_q  <= sum_d;
            end
            rd_valid_q <= rd_en;
            overflow_q <= overflow_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Negative values clamp to zero, so a logical shift is enough here.
    assign rd_shift = rd_mem_q >> SHIFT;

    always_comb begin
        rd_quant = rd_shift[7:0];
        if (rd_mem_q[23])
            rd_quant = 8'h00;
        else if (|rd_shift[23:8])
            rd_quant = 8'hFF;
    end

    assign rd_data  = rd_valid_q ? rd_quant : 8'h00;
    assign rd_valid = rd_valid_q;
    assign busy     = s1_valid_q | s2_valid_q;
    assign overflow = overflow_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_out_accum_buffer.sv
// Scoreboard bench for out_accum_buffer: a reference memory model predicts each readout.
module tb_out_accum_buffer;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              data_validity = 1'b0;
    logic [23:0]       data = '0;
    logic [ADDR_W-1:0] address = '0;
    logic              clr_acc = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              busy;
    logic              overflow;
    logic [ADDR_W:0]   wr_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] mdl_mem [int];
    int          mdl_cnt = 0;
    logic        mdl_ovf = 1'b0;
    logic [7:0]  sb [$];

    out_accum_buffer #(.ADDR_W(ADDR_W), .SHIFT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .data_validity(data_validity),
        .data(data), .address(address), .clr_acc(clr_acc), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .overflow(overflow), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] quant(input logic [23:0] v);
        logic [23:0] s;
        s = v >> 8;
        if (v[23]) return 8'h00;
        if (s > 24'd255) return 8'hFF;
        return s[7:0];
    endfunction

    // Drives one sample for a cycle and applies it to the reference model.
    task automatic drive_wr(input int a, input logic [23:0] d, input logic clr);
        logic [23:0] old, add;
        logic        ov;
        old = mdl_mem.exists(a) ? mdl_mem[a] : 24'h0;
        add = old + d;
        ov  = (old[23] == d[23]) && (add[23] != old[23]);
`ifdef ACC_SAT_EN
        if (ov) add = old[23] ? 24'h800000 : 24'h7FFFFF;
`endif
        if (clr) begin
            mdl_mem[a] = d;
        end else begin
            mdl_mem[a] = add;
            if (ov) mdl_ovf = 1'b1;
        end
        if (mdl_cnt < DEPTH) mdl_cnt++;
        address = 13'(a);
        data = d;
        clr_acc = clr;
        data_validity = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        data_validity = 1'b0;
        clr_acc = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic rd(input int a);
        rd_en = 1'b1;
        rd_addr = 13'(a);
        sb.push_back(quant(mdl_mem[a]));
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(negedge clk); #1;
        chk("rd_latency", sb.size(), 0);
        @(posedge clk); #1;
        chk("rd_valid_low", {31'b0, rd_valid}, 0);
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rd_spurious", {31'b0, rd_valid}, 0);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                chk("rd_data", {24'b0, rd_data}, {24'b0, e});
            end
        end
    end

    initial begin
        bit seen [4];
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 0);
        chk("rst_overflow", {31'b0, overflow}, 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_rd_data", {24'b0, rd_data}, 0);
        rst = 1'b0;
        idle(1);

        // single write, read issued exactly two cycles after acceptance
        drive_wr(5, 24'h000100, 1'b1);
        idle(1);
        rd(5);

        // back-to-back accumulation exercises forwarding
        drive_wr(7, 24'h000200, 1'b1);
        drive_wr(7, 24'h000200, 1'b0);
        drive_wr(7, 24'h000200, 1'b0);
        chk("busy_inflight", {31'b0, busy}, 1);
        idle(2);
        chk("busy_drained", {31'b0, busy}, 0);
        rd(7);
        chk("wr_count_a", 32'(wr_count), 32'(mdl_cnt));

        // negative result clamps to 0, large positive clamps to 255
        drive_wr(3, 24'h000100, 1'b1);
        drive_wr(3, 24'hFFFE00, 1'b0);
        drive_wr(9, 24'h7F0000, 1'b1);
        drive_wr(10, 24'h001234, 1'b1);
        idle(2);
        rd(3);
        rd(9);
        rd(10);

        // random accumulation over a few addresses with occasional gaps
        for (int i = 0; i < 24; i++) begin
            int a;
            logic [23:0] d;
            a = $urandom_range(0, 3);
            d = 24'($urandom_range(0, 24'h0FFFFF));
            if ($urandom_range(0, 1) == 1) d = -d;
            drive_wr(100 + a, d, !seen[a]);
            seen[a] = 1'b1;
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);
        for (int a = 0; a < 4; a++)
            if (seen[a]) rd(100 + a);
        chk("ovf_none", {31'b0, overflow}, {31'b0, mdl_ovf});

        // signed overflow, then start clears the sticky flag and the count
        drive_wr(11, 24'h7FFFFF, 1'b1);
        drive_wr(11, 24'h000001, 1'b0);
        idle(2);
        chk("ovf_set", {31'b0, overflow}, {31'b0, mdl_ovf});
        rd(11);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        chk("start_ovf", {31'b0, overflow}, 0);
        chk("start_cnt", 32'(wr_count), 0);

        // start coinciding with a sample while the previous write lands
        drive_wr(12, 24'h000300, 1'b1);
        start = 1'b1;
        drive_wr(13, 24'h000400, 1'b1);
        start = 1'b0;
        mdl_cnt = 2; // write of sample 12 lands on the start edge and counts as 1
        idle(2);
        chk("start_coincide_cnt", 32'(wr_count), 32'(mdl_cnt));
        rd(12);
        rd(13);

        // reset while a write is in flight drops it
        drive_wr(20, 24'h000500, 1'b1);
        idle(2);
        address = 13'd20;
        data = 24'h000900;
        clr_acc = 1'b1;
        data_validity = 1'b1;
        @(posedge clk); #1;
        data_validity = 1'b0;
        chk("midrst_busy_before", {31'b0, busy}, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_cnt", 32'(wr_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        idle(2);
        chk("midrst_cnt_after", 32'(wr_count), 0);
        rd(20);

        // fill the whole buffer; count reaches depth and saturates
        for (int i = 0; i < DEPTH; i++)
            drive_wr(i, 24'(i) << 8, 1'b1);
        data_validity = 1'b0;
        chk("fill_busy_l1", {31'b0, busy}, 1);
        @(posedge clk); #1;
        chk("fill_busy_l2", {31'b0, busy}, 1);
        @(posedge clk); #1;
        chk("fill_busy_l3", {31'b0, busy}, 0);
        chk("fill_cnt", 32'(wr_count), 32'(DEPTH));
        drive_wr(4, 24'h000100, 1'b0);
        idle(2);
        chk("fill_cnt_sat", 32'(wr_count), 32'(mdl_cnt));
        rd(3);
        rd(4);
        rd(200);
        rd(4000);
        idle(2);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
